// File: rtl/lcd_timing.sv
// lcd_timing: per-line mode sequencer, LY/LYC compare and the
// LCDC/STAT/LY/LYC bus registers with VBLANK and STAT interrupts.
module lcd_timing #(
  parameter int LINE_CYCLES   = 456,
  parameter int OAM_CYCLES    = 80,
  parameter int XFER_CYCLES   = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  input  logic        mem_re,
  input  logic        mem_we,
  output logic        lcd_reg_addr,
  output logic        vblank_int,
  output logic        lcdc_int,
  output logic [7:0]  ly,
  output logic [1:0]  mode
);

  localparam logic [8:0] LP_LAST_DOT  = 9'(LINE_CYCLES - 1);
  localparam logic [8:0] LP_OAM_END   = 9'(OAM_CYCLES);
  localparam logic [8:0] LP_XFER_END  = 9'(OAM_CYCLES + XFER_CYCLES);
  localparam logic [7:0] LP_VIS       = 8'(VISIBLE_LINES);
  localparam logic [7:0] LP_LAST_LINE = 8'(TOTAL_LINES - 1);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } mode_e;

  // OFF: display disabled. ARM: enable seen, first line starts
  // on the following edge. RUN: dot/line counters advancing.
  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nx;
  logic [7:0]  r_lcdc;
  logic [3:0]  r_stat_en;
  logic [7:0]  r_lyc;
  logic [7:0]  r_ly;
  logic [8:0]  r_dot;
  logic        r_stat_line;
  logic        r_lcdc_int;
  logic        r_vblank;

  logic        w_hit_lcdc;
  logic        w_hit_stat;
  logic        w_hit_ly;
  logic        w_hit_lyc;
  logic        w_wr_lcdc;
  logic        w_wr_stat;
  logic        w_wr_ly;
  logic        w_wr_lyc;
  logic [7:0]  w_lcdc_nx;
  logic [3:0]  w_en_nx;
  logic [7:0]  w_lyc_nx;
  logic [7:0]  w_ly_nx;
  logic [8:0]  w_dot_nx;
  mode_e       w_mode;
  mode_e       w_mode_nx;
  logic        w_coinc;
  logic        w_coinc_nx;
  logic        w_stat_nx;
  logic        w_vblank_nx;
  logic [7:0]  w_rdata;

  function automatic mode_e f_mode(
    input logic       run,
    input logic [7:0] l,
    input logic [8:0] d
  );
    mode_e m;
    m = MODE_HBLANK;
    if (!run)              m = MODE_HBLANK;
    else if (l >= LP_VIS)  m = MODE_VBLANK;
    else if (d < LP_OAM_END)  m = MODE_OAM;
    else if (d < LP_XFER_END) m = MODE_XFER;
    else                   m = MODE_HBLANK;
    return m;
  endfunction

  assign w_hit_lcdc   = (addr_ext == 16'hFF40);
  assign w_hit_stat   = (addr_ext == 16'hFF41);
  assign w_hit_ly     = (addr_ext == 16'hFF44);
  assign w_hit_lyc    = (addr_ext == 16'hFF45);
  assign lcd_reg_addr = w_hit_lcdc | w_hit_stat
                      | w_hit_ly | w_hit_lyc;

  assign w_wr_lcdc = mem_we & w_hit_lcdc;
  assign w_wr_stat = mem_we & w_hit_stat;
  assign w_wr_ly   = mem_we & w_hit_ly;
  assign w_wr_lyc  = mem_we & w_hit_lyc;

  // Register values after this edge; a write beats the counters.
  assign w_lcdc_nx = w_wr_lcdc ? data_ext : r_lcdc;
  assign w_en_nx   = w_wr_stat ? data_ext[6:3] : r_stat_en;
  assign w_lyc_nx  = w_wr_lyc ? data_ext : r_lyc;

  assign w_mode    = f_mode(r_state == ST_RUN, r_ly, r_dot);
  assign w_coinc   = (r_ly == r_lyc);

  // Run-state sequencing and dot/line counter next values
  always_comb begin
    w_state_nx = r_state;
    w_ly_nx    = r_ly;
    w_dot_nx   = r_dot;
    if (!w_lcdc_nx[7]) begin
      w_state_nx = ST_OFF;
      w_ly_nx    = 8'd0;
      w_dot_nx   = 9'd0;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          w_state_nx = ST_ARM;
          w_ly_nx    = 8'd0;
          w_dot_nx   = 9'd0;
        end
        ST_ARM: begin
          w_state_nx = ST_RUN;
          w_ly_nx    = 8'd0;
          w_dot_nx   = 9'd0;
        end
        ST_RUN: begin
          if (w_wr_ly) begin
            w_ly_nx  = 8'd0;
            w_dot_nx = 9'd0;
          end else if (r_dot == LP_LAST_DOT) begin
            w_dot_nx = 9'd0;
            w_ly_nx  = (r_ly == LP_LAST_LINE) ? 8'd0
                                              : r_ly + 8'd1;
          end else begin
            w_dot_nx = r_dot + 9'd1;
          end
        end
        default: begin
          w_state_nx = ST_OFF;
          w_ly_nx    = 8'd0;
          w_dot_nx   = 9'd0;
        end
      endcase
    end
  end

  // Interrupt sources evaluated on the post-edge state so each
  // pulse lines up with the cycle that shows its cause.
  always_comb begin
    w_mode_nx   = f_mode(w_state_nx == ST_RUN, w_ly_nx, w_dot_nx);
    w_coinc_nx  = (w_ly_nx == w_lyc_nx);
    w_stat_nx   = (w_state_nx == ST_RUN)
                & ((w_en_nx[3] & w_coinc_nx)
                 | (w_en_nx[2] & (w_mode_nx == MODE_OAM))
                 | (w_en_nx[1] & (w_mode_nx == MODE_VBLANK))
                 | (w_en_nx[0] & (w_mode_nx == MODE_HBLANK)));
    w_vblank_nx = (w_state_nx == ST_RUN)
                & (w_ly_nx == LP_VIS) & (r_ly != LP_VIS);
  end

  // State, counters, bus registers and interrupt pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_OFF;
      r_lcdc      <= 8'h00;
      r_stat_en   <= 4'h0;
      r_lyc       <= 8'h00;
      r_ly        <= 8'h00;
      r_dot       <= 9'd0;
      r_stat_line <= 1'b0;
      r_lcdc_int  <= 1'b0;
      r_vblank    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_lcdc      <= w_lcdc_nx;
      r_stat_en   <= w_en_nx;
      r_lyc       <= w_lyc_nx;
      r_ly        <= w_ly_nx;
      r_dot       <= w_dot_nx;
      r_stat_line <= w_stat_nx;
      r_lcdc_int  <= w_stat_nx & ~r_stat_line;
      r_vblank    <= w_vblank_nx;
    end
  end

  // Read data mux for the four mapped registers
  always_comb begin
    w_rdata = 8'h00;
    unique case (1'b1)
      w_hit_lcdc: w_rdata = r_lcdc;
      w_hit_stat: w_rdata = {1'b1, r_stat_en, w_coinc, w_mode};
      w_hit_ly:   w_rdata = r_ly;
      w_hit_lyc:  w_rdata = r_lyc;
      default:    w_rdata = 8'h00;
    endcase
  end

  assign data_ext   = (mem_re & lcd_reg_addr) ? w_rdata : 8'bz;
  assign ly         = r_ly;
  assign mode       = w_mode;
  assign vblank_int = r_vblank;
  assign lcdc_int   = r_lcdc_int;

endmodule

// File: tb/tb_lcd_timing.sv
// tb_lcd_timing: directed stimulus with per-output expectation
// queues drained by a negedge monitor.
module tb_lcd_timing;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr_ext = 16'h0000;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_dat = 8'h00;
  wire  [7:0]  data_ext;
  logic        lcd_reg_addr;
  logic        vblank_int;
  logic        lcdc_int;
  logic [7:0]  ly;
  logic [1:0]  mode;

  assign data_ext = tb_drv ? tb_dat : 8'bz;

  lcd_timing dut (
    .clock        (clock),
    .reset        (reset),
    .addr_ext     (addr_ext),
    .data_ext     (data_ext),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .lcd_reg_addr (lcd_reg_addr),
    .vblank_int   (vblank_int),
    .lcdc_int     (lcdc_int),
    .ly           (ly),
    .mode         (mode)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int stamp;
    int val;
  } exp_t;

  exp_t q_rd[$];
  exp_t q_vb[$];
  exp_t q_st[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d", nm, cyc);
  endtask

  // Monitor: every presented output consumes one expectation
  always @(negedge clock) begin
    if (mem_re && lcd_reg_addr) begin
      if (q_rd.size() == 0) note_fail("unexpected read");
      else begin
        me = q_rd.pop_front();
        chk($sformatf("rd@%0d", me.stamp), 32'(data_ext),
            32'(me.val));
      end
    end
    if (vblank_int) begin
      if (q_vb.size() == 0) note_fail("unexpected vblank_int");
      else begin
        me = q_vb.pop_front();
        chk("vblank_cyc", 32'(cyc), 32'(me.stamp));
        chk("vblank_ly", 32'(ly), 32'(me.val));
      end
    end
    if (lcdc_int) begin
      if (q_st.size() == 0) note_fail("unexpected lcdc_int");
      else begin
        me = q_st.pop_front();
        chk("lcdc_cyc", 32'(cyc), 32'(me.stamp));
        chk("lcdc_ly", 32'(ly), 32'(me.val));
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d,
                    output int e);
    addr_ext = a;
    tb_dat   = d;
    tb_drv   = 1'b1;
    mem_we   = 1'b1;
    @(posedge clock);
    #2;
    e      = cyc;
    mem_we = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] x);
    q_rd.push_back('{stamp: cyc, val: int'(x)});
    addr_ext = a;
    mem_re   = 1'b1;
    @(negedge clock);
    #1;
    mem_re = 1'b0;
    @(posedge clock);
    #2;
  endtask

  task automatic wait_until(input int c);
    if (cyc > c) note_fail($sformatf("late for cycle %0d", c));
    while (cyc < c) begin
      @(posedge clock);
      #2;
    end
  endtask

  logic [15:0] tab_a [9] = '{16'hFF40, 16'hFF41, 16'hFF42,
                             16'hFF43, 16'hFF44, 16'hFF45,
                             16'hFF46, 16'hFF0F, 16'h0040};
  logic        tab_h [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int e, s, d, r, w;
    #1;
    chk("rst_ly", 32'(ly), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_ints", 32'({vblank_int, lcdc_int}), 32'd0);
    chk("rst_hiz", 32'(data_ext === 8'bz), 32'd1);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;

    rd(16'hFF40, 8'h00);
    rd(16'hFF41, 8'h84);
    rd(16'hFF44, 8'h00);
    rd(16'hFF45, 8'h00);
    for (int i = 0; i < 9; i++) begin
      addr_ext = tab_a[i];
      #1;
      chk($sformatf("reg_addr_%h", tab_a[i]),
          32'(lcd_reg_addr), 32'(tab_h[i]));
    end
    addr_ext = 16'hFF42;
    mem_re   = 1'b1;
    #1;
    chk("miss_hiz", 32'(data_ext === 8'bz), 32'd1);
    mem_re = 1'b0;
    @(posedge clock);
    #2;

    wr(16'hFF41, 8'hFF, e);
    rd(16'hFF41, 8'hFC);
    wr(16'hFF45, 8'h5A, e);
    rd(16'hFF45, 8'h5A);
    wr(16'hFF45, 8'h00, e);
    wr(16'hFF40, 8'h13, e);
    rd(16'hFF40, 8'h13);
    wr(16'hFF44, 8'h07, e);
    rd(16'hFF44, 8'h00);
    wr(16'hFF41, 8'h08, e);
    rd(16'hFF41, 8'h8C);

    wr(16'hFF40, 8'h91, e);
    s = e + 1;
    for (int l = 0; l < 144; l++)
      q_st.push_back('{stamp: s + 456 * l + 252, val: l});
    q_vb.push_back('{stamp: s + 65664, val: 144});
    rd(16'hFF41, 8'h8C);
    wait_until(s);
    rd(16'hFF41, 8'h8E);
    wait_until(s + 79);
    rd(16'hFF41, 8'h8E);
    rd(16'hFF41, 8'h8F);
    wait_until(s + 251);
    rd(16'hFF41, 8'h8F);
    rd(16'hFF41, 8'h8C);
    wait_until(s + 455);
    rd(16'hFF41, 8'h8C);
    rd(16'hFF44, 8'h01);
    rd(16'hFF41, 8'h8A);

    wait_until(s + 65663);
    rd(16'hFF44, 8'd143);
    rd(16'hFF41, 8'h89);
    wait_until(s + 70223);
    rd(16'hFF44, 8'd153);
    rd(16'hFF44, 8'h00);

    wr(16'hFF45, 8'h05, e);
    wr(16'hFF41, 8'h40, e);
    q_st.push_back('{stamp: s + 72504, val: 5});
    wait_until(s + 72504);
    rd(16'hFF41, 8'hC6);
    wait_until(s + 72959);
    rd(16'hFF41, 8'hC4);
    rd(16'hFF41, 8'hC2);

    wait_until(s + 73972);
    chk("ly_before_off", 32'(ly), 32'd8);
    wr(16'hFF40, 8'h11, d);
    rd(16'hFF44, 8'h00);
    rd(16'hFF41, 8'hC0);
    chk("off_ly_mode", 32'({ly, mode}), 32'd0);
    wait_until(d + 1000);
    wr(16'hFF45, 8'h00, e);
    rd(16'hFF41, 8'hC4);
    repeat (20) @(posedge clock);
    #2;
    wr(16'hFF40, 8'h91, r);
    q_st.push_back('{stamp: r + 1, val: 0});
    rd(16'hFF41, 8'hC4);
    rd(16'hFF41, 8'hC6);
    wait_until(r + 467);
    chk("ly_before_restart", 32'(ly), 32'd1);
    wr(16'hFF44, 8'hAA, w);
    q_st.push_back('{stamp: w, val: 0});
    rd(16'hFF44, 8'h00);
    rd(16'hFF41, 8'hC6);
    chk("restart_ly", 32'(ly), 32'd0);
    chk("restart_mode", 32'(mode), 32'd2);

    wait_until(w + 600);
    chk("pre_reset_mode", 32'(mode), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst", 32'({ly, mode, vblank_int, lcdc_int}), 32'd0);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #2;
    rd(16'hFF40, 8'h00);
    rd(16'hFF41, 8'h84);
    repeat (3) @(posedge clock);
    #2;

    chk("queues_drained", 32'(q_rd.size() + q_vb.size()
        + q_st.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    note_fail("timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
